// File: rtl/id_fetch_queue.sv
// Instruction fetch queue with early decode of J/Branch/target/imm for the PC stage.
// Optional build macro ID_BYPASS_EN: an ack into an empty queue is presented combinationally.
module id_fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        init,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  output logic        pc_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        J,
  output logic        Branch,
  output logic [25:0] target,
  output logic [15:0] imm
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];

  logic fifo_valid;
  logic bypass;
  logic accept;
  logic push;
  logic pop;
  logic [5:0] opcode;

  assign fifo_valid = (count != '0);
  assign pc_ready   = (state == IDLE) && (count < FULL) && !flush && !init;
  assign accept     = pc_valid && pc_ready;

`ifdef ID_BYPASS_EN
  assign bypass = (state == WAIT) && imem_ack && !flush && !fifo_valid;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that is consumed in the same cycle never enters the queue.
  assign push = (state == WAIT) && imem_ack && !flush && !(bypass && out_ready);
  assign pop  = fifo_valid && out_ready && !flush;

  // Fetch handshake and queue bookkeeping; flush clears the queue but the
  // outstanding request must still be retired by its ack.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= 32'd0;
      count     <= '0;
      head      <= '0;
      tail      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= WAIT;
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end else if (flush) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (imem_ack) begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase

      if (flush) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[tail]    <= imem_addr;
      mem_instr[tail] <= imem_rdata;
    end
  end

  // Head entry takes precedence; the bypass path only exists while the queue is empty.
  always_comb begin
    out_pc    = 32'd0;
    out_instr = 32'd0;
    if (fifo_valid) begin
      out_pc    = mem_pc[head];
      out_instr = mem_instr[head];
    end else if (bypass) begin
      out_pc    = imem_addr;
      out_instr = imem_rdata;
    end
  end

  assign out_valid = fifo_valid || bypass;
  assign opcode    = out_instr[31:26];
  assign J         = out_valid && ((opcode == 6'b000010) || (opcode == 6'b000011));
  assign Branch    = out_valid && (opcode == 6'b000100);
  assign target    = out_instr[25:0];
  assign imm       = out_instr[15:0];

endmodule

// File: tb/tb_id_fetch_queue.sv
// Self-checking bench for id_fetch_queue: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_id_fetch_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        init;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        J;
  logic        Branch;
  logic [25:0] target;
  logic [15:0] imm;

  always #5 clk = ~clk;

  id_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .init(init), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .J(J), .Branch(Branch),
    .target(target), .imm(imm)
  );

  // Reference model: the queue holds {pc, instr} pairs; pend/drop describe the single
  // outstanding memory request and whether its result is to be thrown away.
  logic [63:0] mq[$];
  bit          pend = 1'b0;
  bit          drop = 1'b0;
  logic [31:0] paddr = 32'd0;
  logic [31:0] popped[$];

  int checks = 0;
  int passes = 0;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic bit modelReady();
    return !pend && (mq.size() < DEPTH) && !flush && !init;
  endfunction

  function automatic bit modelBypass();
`ifdef ID_BYPASS_EN
    return pend && !drop && imem_ack && !flush && (mq.size() == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput();
    bit          byp;
    bit          valid;
    logic [63:0] head;
    logic [5:0]  op;
    byp   = modelBypass();
    valid = (mq.size() != 0) || byp;
    head  = (mq.size() != 0) ? mq[0] : {paddr, imem_rdata};
    op    = head[31:26];
    checkEq("pc_ready", pc_ready, modelReady());
    checkEq("imem_req", imem_req, pend);
    checkEq("imem_addr", imem_addr, paddr);
    checkEq("out_valid", out_valid, valid);
    checkEq("J", J, valid && (op == 6'h02 || op == 6'h03));
    checkEq("Branch", Branch, valid && (op == 6'h04));
    if (valid) begin
      checkEq("out_pc", out_pc, head[63:32]);
      checkEq("out_instr", out_instr, head[31:0]);
      checkEq("target", target, head[25:0]);
      checkEq("imm", imm, head[15:0]);
      if (out_ready) popped.push_back(out_pc);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and compare; an init request is a
  // short pulse that ends before the next rising edge.
  task automatic applyStimulus(input bit pv, input logic [31:0] p, input bit ack,
                               input logic [31:0] rd, input bit fl, input bit ordy,
                               input bit rst);
    @(negedge clk);
    pc_valid   = pv;
    pc         = p;
    imem_ack   = ack;
    imem_rdata = rd;
    flush      = fl;
    out_ready  = ordy;
    if (rst) begin
      init = 1'b1;
      mq.delete();
      pend  = 1'b0;
      drop  = 1'b0;
      paddr = 32'd0;
    end
    #1;
    checkOutput();
    if (rst) begin
      #1 init = 1'b0;
    end
  endtask

  task automatic advance();
    bit acc;
    bit pop;
    bit byp;
    @(posedge clk);
    if (!init) begin
      acc = pc_valid && modelReady();
      pop = (mq.size() != 0) && out_ready;
      byp = modelBypass();
      if (flush) begin
        mq.delete();
        if (pend && imem_ack) begin
          pend = 1'b0;
          drop = 1'b0;
        end else if (pend) begin
          drop = 1'b1;
        end
      end else begin
        if (pop) void'(mq.pop_front());
        if (pend && imem_ack) begin
          if (!drop && !(byp && out_ready)) mq.push_back({paddr, imem_rdata});
          pend = 1'b0;
          drop = 1'b0;
        end
        if (acc) begin
          pend  = 1'b1;
          drop  = 1'b0;
          paddr = pc;
        end
      end
    end
  endtask

  task automatic idle(input bit ordy);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, ordy, 1'b0);
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] word);
    applyStimulus(1'b1, addr, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    advance();
    applyStimulus(1'b0, 32'd0, 1'b1, word, 1'b0, 1'b0, 1'b0);
    advance();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          nacc;
    logic [31:0] rp;
    logic [5:0]  op;
    init = 1'b1; pc_valid = 1'b0; pc = 32'd0; imem_ack = 1'b0;
    imem_rdata = 32'd0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    checkEq("reset imem_req", imem_req, 0);
    checkEq("reset imem_addr", imem_addr, 0);
    checkEq("reset out_valid", out_valid, 0);
    advance();

    // Single jump fetch
    applyStimulus(1'b1, 32'h10, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkEq("first pc_ready", pc_ready, 1);
    advance();
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h0800_0004, 1'b0, 1'b0, 1'b0);
    checkEq("req after accept", imem_req, 1);
    checkEq("addr after accept", imem_addr, 32'h10);
    advance();
    idle(1'b0);
    checkEq("j out_valid", out_valid, 1);
    checkEq("j out_pc", out_pc, 32'h10);
    checkEq("j J", J, 1);
    checkEq("j target", target, 26'h4);
    checkEq("j imm", imm, 16'h0004);
    advance();
    idle(1'b1); advance();
    idle(1'b0);
    checkEq("empty after pop", out_valid, 0);
    advance();

    // beq decode, then Branch gated when empty
    fetch(32'h20, 32'h1000_FFFF);
    idle(1'b0);
    checkEq("beq Branch", Branch, 1);
    checkEq("beq J", J, 0);
    checkEq("beq imm", imm, 16'hFFFF);
    advance();
    idle(1'b1); advance();
    idle(1'b0);
    checkEq("empty Branch", Branch, 0);
    advance();

    // Fill to DEPTH, third pc refused until a pop
    fetch(32'h100, 32'h2000_0001);
    fetch(32'h104, 32'h2000_0002);
    applyStimulus(1'b1, 32'h108, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkEq("full refuses", pc_ready, 0);
    advance();
    applyStimulus(1'b1, 32'h108, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    checkEq("fill head 0", out_pc, 32'h100);
    advance();
    applyStimulus(1'b1, 32'h108, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkEq("space after pop", pc_ready, 1);
    advance();
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h2000_0003, 1'b0, 1'b0, 1'b0);
    advance();
    idle(1'b1);
    checkEq("fill head 1", out_pc, 32'h104);
    advance();
    idle(1'b1);
    checkEq("fill head 2", out_pc, 32'h108);
    advance();

    // Flush while the request is outstanding
    applyStimulus(1'b1, 32'h200, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    advance();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    advance();
    idle(1'b0);
    checkEq("drop pc_ready", pc_ready, 0);
    advance();
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h0800_0099, 1'b0, 1'b0, 1'b0);
    checkEq("drop ack pc_ready", pc_ready, 0);
    advance();
    idle(1'b0);
    checkEq("after drop pc_ready", pc_ready, 1);
    checkEq("after drop out_valid", out_valid, 0);
    advance();

    // Async init pulse mid-fetch; the stale ack must be ignored
    applyStimulus(1'b1, 32'h300, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    advance();
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    checkEq("init drops req", imem_req, 0);
    advance();
    applyStimulus(1'b0, 32'd0, 1'b1, 32'h0800_0055, 1'b0, 1'b0, 1'b0);
    advance();
    idle(1'b0);
    checkEq("stale ack out_valid", out_valid, 0);
    advance();

    // Back-to-back fetches with zero-wait memory: pointers wrap, order preserved
    popped.delete();
    nacc = 0;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(nacc < 10, 32'(32'h400 + nacc * 4), 1'b1, $urandom(), 1'b0, 1'b1, 1'b0);
      if (pc_valid && modelReady()) nacc++;
      advance();
    end
    checkEq("wrap pop count", popped.size(), 10);
    for (int i = 0; i < popped.size() && i < 10; i++)
      checkEq("wrap order", popped[i], 32'(32'h400 + i * 4));

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rp = $urandom();
      rp[1:0] = 2'b00;
      case ($urandom_range(0, 3))
        0:       op = 6'h02;
        1:       op = 6'h03;
        2:       op = 6'h04;
        default: op = 6'($urandom());
      endcase
      applyStimulus($urandom_range(0, 1) == 1, rp, $urandom_range(0, 2) == 0,
                    {op, 26'($urandom())}, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
      advance();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
